// File: rtl/rca_pipe_clk.sv
// rca_pipe_clk: pipelined ripple-carry adder/subtractor.
// A WIDTH-bit add (or subtract via inverted B plus carry-in of one) is split
// into STAGES ripple chunks of CHUNK bits each. Chunk k is summed in the cycle
// between pipeline register k and k+1. Already finished low sum bits ride
// along unchanged, so every bit of one operation leaves the pipe together.
// A valid bit travels with each slot; en=0 freezes the whole pipe.
module rca_pipe_clk #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov
);

    localparam int CHUNK = WIDTH / STAGES;

    // Bit-serial ripple of one chunk: returns {carry_out, chunk_sum}.
    function automatic logic [CHUNK:0] rca_chunk(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             cin
    );
        logic [CHUNK-1:0] sum_v;
        logic             c_v;
        c_v = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum_v[i] = x[i] ^ y[i] ^ c_v;
            c_v      = (x[i] & y[i]) | (x[i] & c_v) | (y[i] & c_v);
        end
        return {c_v, sum_v};
    endfunction

    // Slot k holds the state after pipeline register k (0 = input register).
    logic             valid_r [0:STAGES];
    logic [WIDTH-1:0] sum_r   [0:STAGES];
    logic             carry_r [0:STAGES];
    logic [WIDTH-1:0] opa_r   [0:STAGES-1];
    logic [WIDTH-1:0] opb_r   [0:STAGES-1];
    logic             ov_r;

    logic [CHUNK:0]   add_s    [0:STAGES-1];
    logic [WIDTH-1:0] merged_s [0:STAGES-1];
    logic             ov_s;

    // Per-stage chunk ripple, merge into the partial sum, and overflow from the sign bits.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            add_s[k]    = rca_chunk(opa_r[k][k*CHUNK +: CHUNK],
                                    opb_r[k][k*CHUNK +: CHUNK],
                                    carry_r[k]);
            merged_s[k] = sum_r[k];
            merged_s[k][k*CHUNK +: CHUNK] = add_s[k][CHUNK-1:0];
        end
        // Overflow: operands of equal sign producing a result of the other sign.
        ov_s = (opa_r[STAGES-1][WIDTH-1] == opb_r[STAGES-1][WIDTH-1]) &&
               (merged_s[STAGES-1][WIDTH-1] != opa_r[STAGES-1][WIDTH-1]);
    end

    // Pipeline registers: async clear, advance only when en=1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k <= STAGES; k++) begin
                valid_r[k] <= 1'b0;
                sum_r[k]   <= '0;
                carry_r[k] <= 1'b0;
            end
            for (int k = 0; k < STAGES; k++) begin
                opa_r[k] <= '0;
                opb_r[k] <= '0;
            end
            ov_r <= 1'b0;
        end else if (en) begin
            // Input register: subtract is a + ~b + 1, ci ignored.
            valid_r[0] <= in_valid;
            sum_r[0]   <= '0;
            carry_r[0] <= sub ? 1'b1 : ci;
            opa_r[0]   <= a;
            opb_r[0]   <= sub ? ~b : b;
            for (int k = 1; k <= STAGES; k++) begin
                valid_r[k] <= valid_r[k-1];
                sum_r[k]   <= merged_s[k-1];
                carry_r[k] <= add_s[k-1][CHUNK];
            end
            for (int k = 1; k < STAGES; k++) begin
                opa_r[k] <= opa_r[k-1];
                opb_r[k] <= opb_r[k-1];
            end
            ov_r <= ov_s;
        end
    end

    assign out_valid = valid_r[STAGES];
    assign s         = sum_r[STAGES];
    assign co        = carry_r[STAGES];
    assign ov        = ov_r;

endmodule

// File: tb/tb_rca_pipe_clk.sv
// Self-checking bench for rca_pipe_clk: table vectors, random stream,
// stall, asynchronous mid-stream reset, and a width/stage sweep.
module tb_rca_pipe_clk;

    logic        clk = 1'b0;
    logic        reset_n, en, in_valid, ci, sub;
    logic [31:0] a, b;
    logic        out_valid, co, ov;
    logic [31:0] s;

    // sweep instances
    logic        sw_valid;
    logic [7:0]  a8,  b8,  s8;
    logic [15:0] a16, b16, s16;
    logic [63:0] a64, b64, s64;
    logic        v8, v16, v64, co8, co16, co64, ov8, ov16, ov64;

    always #5 clk = ~clk;

    rca_pipe_clk #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .in_valid(in_valid),
        .a(a), .b(b), .ci(ci), .sub(sub),
        .out_valid(out_valid), .s(s), .co(co), .ov(ov));

    rca_pipe_clk #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .reset_n(reset_n), .en(en), .in_valid(sw_valid),
        .a(a8), .b(b8), .ci(ci), .sub(1'b0),
        .out_valid(v8), .s(s8), .co(co8), .ov(ov8));

    rca_pipe_clk #(.WIDTH(16), .STAGES(2)) dut16 (
        .clk(clk), .reset_n(reset_n), .en(en), .in_valid(sw_valid),
        .a(a16), .b(b16), .ci(ci), .sub(1'b0),
        .out_valid(v16), .s(s16), .co(co16), .ov(ov16));

    rca_pipe_clk #(.WIDTH(64), .STAGES(8)) dut64 (
        .clk(clk), .reset_n(reset_n), .en(en), .in_valid(sw_valid),
        .a(a64), .b(b64), .ci(ci), .sub(1'b0),
        .out_valid(v64), .s(s64), .co(co64), .ov(ov64));

    typedef struct packed {
        logic        v;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        sub;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs [9];
    exp_t exp_q [$];

    int n_pass  = 0;
    int n_total = 0;

    logic        last_v, last_co, last_ov;
    logic [31:0] last_s;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    endtask

    // Reference: exact signed/unsigned arithmetic, independent of gate structure.
    function automatic exp_t ref_add(input logic [31:0] ra, input logic [31:0] rb,
                                     input logic rci, input logic rsub);
        exp_t               r;
        logic signed [33:0] sa, sb, t;
        logic [32:0]        u;
        sa = {{2{ra[31]}}, ra};
        sb = {{2{rb[31]}}, rb};
        if (rsub) t = sa - sb;
        else      t = sa + sb + $signed({33'd0, rci});
        u    = {1'b0, ra} + {1'b0, rb} + {32'd0, rci};
        r.v  = 1'b1;
        r.s  = t[31:0];
        r.co = rsub ? (ra >= rb) : u[32];
        r.ov = (t[33:31] != 3'b000) && (t[33:31] != 3'b111);
        return r;
    endfunction

    // After reset the pipe holds four empty slots that drain first.
    task automatic prefill();
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back('0);
    endtask

    task automatic step(input logic e, input logic v, input logic [31:0] ta, input logic [31:0] tb,
                        input logic tci, input logic tsub, input exp_t ex);
        exp_t got;
        @(negedge clk);
        en = e; in_valid = v; a = ta; b = tb; ci = tci; sub = tsub;
        ex.v = v;
        if (e) exp_q.push_back(ex);
        @(posedge clk);
        #1;
        if (e) begin
            if (exp_q.size() == 0) begin
                check("queue_underflow", 64'd1, 64'd0);
            end else begin
                got = exp_q.pop_front();
                check("out_valid", {63'd0, out_valid}, {63'd0, got.v});
                if (got.v) begin
                    check("s",  {32'd0, s},  {32'd0, got.s});
                    check("co", {63'd0, co}, {63'd0, got.co});
                    check("ov", {63'd0, ov}, {63'd0, got.ov});
                end
            end
        end else begin
            check("stall_valid", {63'd0, out_valid}, {63'd0, last_v});
            check("stall_s",  {32'd0, s},  {32'd0, last_s});
            check("stall_co", {63'd0, co}, {63'd0, last_co});
            check("stall_ov", {63'd0, ov}, {63'd0, last_ov});
        end
        last_v = out_valid; last_s = s; last_co = co; last_ov = ov;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, '0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_s"},  {32'd0, s},  64'd0);
        check({tag, "_co"}, {63'd0, co}, 64'd0);
        check({tag, "_ov"}, {63'd0, ov}, 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   lat8, lat16, lat64;
        exp_t e;
        logic [31:0] ra, rb;
        logic        rci, rsub, rv;

        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[4] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[6] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[8] = '{32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0001_0001, 1'b0, 1'b0};

        reset_n = 1'b0; en = 1'b0; in_valid = 1'b0; a = 32'd0; b = 32'd0; ci = 1'b0; sub = 1'b0;
        sw_valid = 1'b0; a8 = 8'd0; b8 = 8'd1; a16 = 16'd0; b16 = 16'd1; a64 = 64'd0; b64 = 64'd1;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        prefill();
        last_v = 1'b0; last_s = 32'd0; last_co = 1'b0; last_ov = 1'b0;

        // directed vectors streamed back-to-back
        for (int i = 0; i < 9; i++) begin
            e.v = 1'b1; e.s = vecs[i].s; e.co = vecs[i].co; e.ov = vecs[i].ov;
            step(1'b1, 1'b1, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub, e);
        end
        drain(4);

        // random stream with random valid
        for (int i = 0; i < 100; i++) begin
            ra = $urandom; rb = $urandom;
            rci = 1'($urandom_range(0, 1)); rsub = 1'($urandom_range(0, 1));
            rv  = 1'($urandom_range(0, 1));
            step(1'b1, rv, ra, rb, rci, rsub, ref_add(ra, rb, rci, rsub));
        end
        drain(4);

        // stall mid-flight: three ops, four frozen cycles with changing inputs
        for (int i = 0; i < 3; i++) begin
            ra = $urandom; rb = $urandom;
            step(1'b1, 1'b1, ra, rb, 1'b1, 1'(i), ref_add(ra, rb, 1'b1, 1'(i)));
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, $urandom, $urandom, 1'b1, 1'b0, '0);
        drain(5);

        // asynchronous reset with operations in flight
        for (int i = 0; i < 5; i++) begin
            ra = 32'(i + 1); rb = 32'(2 * i + 2);
            step(1'b1, 1'b1, ra, rb, 1'b0, 1'b0, ref_add(ra, rb, 1'b0, 1'b0));
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("async_reset");
        prefill();
        last_v = 1'b0; last_s = 32'd0; last_co = 1'b0; last_ov = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        drain(6);

        // parameter sweep: all-ones + 1 + carry-in 1 = 1 with carry out
        @(negedge clk);
        en = 1'b1; in_valid = 1'b0; ci = 1'b1; sub = 1'b0;
        sw_valid = 1'b1; a8 = '1; a16 = '1; a64 = '1;
        lat8 = 0; lat16 = 0; lat64 = 0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) sw_valid = 1'b0;
            if (v8 && lat8 == 0) begin
                lat8 = n;
                check("sw8_s",  {56'd0, s8},  64'd1);
                check("sw8_co", {63'd0, co8}, 64'd1);
            end
            if (v16 && lat16 == 0) begin
                lat16 = n;
                check("sw16_s",  {48'd0, s16},  64'd1);
                check("sw16_co", {63'd0, co16}, 64'd1);
            end
            if (v64 && lat64 == 0) begin
                lat64 = n;
                check("sw64_s",  s64,  64'd1);
                check("sw64_co", {63'd0, co64}, 64'd1);
                check("sw64_ov", {63'd0, ov64}, 64'd0);
            end
        end
        check("sw8_latency",  64'(lat8),  64'd2);
        check("sw16_latency", 64'(lat16), 64'd3);
        check("sw64_latency", 64'(lat64), 64'd9);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
